bus_arbiter: RTL

- Shares the single Bridge data bus between two masters. Master 0 is the CPU MEM stage; master 1 is a secondary master (DMA / debug loader).
- Sits between the pipeline's MEM-stage bus signals and the Bridge.
- Does round-robin arbitration, with a bounded lock (burst) for master 1.
- Raises cpu_stall so the pipeline freezes whenever the CPU is denied the bus.
- Every granted access completes in the cycle it is granted, because the Bridge read is combinational.

---
 rtl/bus_arbiter_pkg.sv | 9 +
 rtl/arb_stats.sv | 42 ++++
 rtl/bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the two-master Bridge bus arbiter: master indices and
// the default burst lock length.
package bus_arbiter_pkg;

  localparam logic ARB_M0        = 1'b0;
  localparam logic ARB_M1        = 1'b1;
  localparam int   BURST_MAX_DEF = 8;

endpackage

// File: rtl/arb_stats.sv
// Saturating statistics counters for the bus arbiter (conflicts, CPU stalls,
// forced yields); instantiated only when ARB_STATS_EN is defined.
module arb_stats #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stat_clr,
  input  logic              conflict,
  input  logic              stall,
  input  logic              yield_ev,
  output logic [STAT_W-1:0] stat_conflict,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_yield
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == {STAT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Event counters: async clear on reset, sync clear on stat_clr, else saturate-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflict <= {STAT_W{1'b0}};
      stat_stall    <= {STAT_W{1'b0}};
      stat_yield    <= {STAT_W{1'b0}};
    end else if (stat_clr) begin
      stat_conflict <= {STAT_W{1'b0}};
      stat_stall    <= {STAT_W{1'b0}};
      stat_yield    <= {STAT_W{1'b0}};
    end else begin
      stat_conflict <= conflict ? sat_inc(stat_conflict) : stat_conflict;
      stat_stall    <= stall    ? sat_inc(stat_stall)    : stat_stall;
      stat_yield    <= yield_ev ? sat_inc(stat_yield)    : stat_yield;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the Bridge bus between the CPU (m0) and a
// secondary master (m1) with a bounded m1 burst lock. Optional ARB_STATS_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
`ifdef ARB_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_gnt,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_gnt,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata,
  output logic        cpu_stall
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_conflict,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_yield
`endif
);

  localparam int              CNT_W       = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

  logic             last_gnt_r;
  logic             lock_act_r;
  logic [CNT_W-1:0] burst_cnt_r;

  logic gnt_m0_s;
  logic gnt_m1_s;
  logic yield_s;
  logic at_max_s;

  assign at_max_s = (burst_cnt_r == BURST_MAX_C);

  // Grant selection: lock hold, forced yield, single requester, then round-robin.
  always_comb begin
    gnt_m0_s = 1'b0;
    gnt_m1_s = 1'b0;
    yield_s  = 1'b0;
    if (cpu_rst) begin
      gnt_m0_s = 1'b0;
    end else if (lock_act_r && m1_req && m1_lock && (!at_max_s || !m0_req)) begin
      gnt_m1_s = 1'b1;
    end else if (lock_act_r && m0_req && at_max_s) begin
      gnt_m0_s = 1'b1;
      yield_s  = 1'b1;
    end else if (m0_req && !m1_req) begin
      gnt_m0_s = 1'b1;
    end else if (m1_req && !m0_req) begin
      gnt_m1_s = 1'b1;
    end else if (m0_req && m1_req) begin
      if (last_gnt_r == ARB_M1) begin
        gnt_m0_s = 1'b1;
      end else begin
        gnt_m1_s = 1'b1;
      end
    end else begin
      gnt_m1_s = 1'b0;
    end
  end

  // Bus and read-data steering from whichever master holds the grant.
  always_comb begin
    Bus_addr  = 32'h0000_0000;
    Bus_wdata = 32'h0000_0000;
    Bus_wen   = 1'b0;
    m0_rdata  = 32'h0000_0000;
    m1_rdata  = 32'h0000_0000;
    case ({gnt_m1_s, gnt_m0_s})
      2'b01: begin
        Bus_addr  = m0_addr;
        Bus_wdata = m0_wdata;
        Bus_wen   = m0_wen;
        m0_rdata  = Bus_rdata;
      end
      2'b10: begin
        Bus_addr  = m1_addr;
        Bus_wdata = m1_wdata;
        Bus_wen   = m1_wen;
        m1_rdata  = Bus_rdata;
      end
      default: begin
        Bus_wen = 1'b0;
      end
    endcase
  end

  assign m0_gnt    = gnt_m0_s;
  assign m1_gnt    = gnt_m1_s;
  assign cpu_stall = m0_req & ~gnt_m0_s & ~cpu_rst;

  // Arbitration history; any cycle without an m1 grant drops the lock and its count.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      last_gnt_r  <= ARB_M1;
      lock_act_r  <= 1'b0;
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (gnt_m0_s) begin
        last_gnt_r <= ARB_M0;
      end else if (gnt_m1_s) begin
        last_gnt_r <= ARB_M1;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
      lock_act_r <= gnt_m1_s & m1_lock;
      if (gnt_m1_s && lock_act_r && m0_req) begin
        burst_cnt_r <= at_max_s ? burst_cnt_r : burst_cnt_r + CNT_ONE_C;
      end else begin
        burst_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

`ifdef ARB_STATS_EN
  arb_stats #(
    .STAT_W(STAT_W)
  ) u_arb_stats (
    .clk          (cpu_clk),
    .rst          (cpu_rst),
    .stat_clr     (stat_clr),
    .conflict     (m0_req & m1_req),
    .stall        (cpu_stall),
    .yield_ev     (yield_s),
    .stat_conflict(stat_conflict),
    .stat_stall   (stat_stall),
    .stat_yield   (stat_yield)
  );
`else
  logic unused_yield_s;
  assign unused_yield_s = yield_s;
`endif

endmodule
